reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//   Circular in-order buffer of ROB_PACKET entries between dispatch and retire.
//   Dispatch writes up to N entries per cycle at the tail. The oldest up to N entries are presented to the retire stage.
//   Retire returns num_retiring, and that many entries are popped at the head.
//   Also reports free space to dispatch and supports a full flush on mispredict or exception.
// PARAMETERS
//   DEPTH  `ROB_SZ  number of entries; need not be a power of two, must be >= N
//   WIDTH  `N       superscalar width: max dispatch/retire per cycle
// PORTS
//   clock                 in   1                      system clock; reset is synchronous, active-high
//   reset                 in   1                      clears all state on the next clock edge
//   rob_inputs            in   N x ROB_PACKET         dispatch entries; lanes 0..rob_inputs_valid-1 are meaningful
//   rob_inputs_valid      in   NUM_SCALAR_BITS        count of entries written this cycle (0..N)
//   rob_spots             out  NUM_SCALAR_BITS        min(DEPTH-count, N); registered count only
//   rob_outputs           out  N x ROB_PACKET         lane i = entry at (head+i) mod DEPTH
//   rob_outputs_valid     out  NUM_SCALAR_BITS        min(count, N)
//   num_retiring          in   NUM_SCALAR_BITS        entries retire consumes this cycle (0..rob_outputs_valid)
//   flush                 in   1                      squash every entry
//   rob_tail              out  $clog2(DEPTH)          index the next dispatched lane-0 entry will occupy
// BEHAVIOUR
//   State: entries[DEPTH], head, tail, count (0..DEPTH, $clog2(DEPTH+1) bits).
//   Outputs:
//     - rob_outputs, rob_outputs_valid, rob_spots and rob_tail are combinational from registered state only.
//     - No same-cycle bypass: a retire does not raise rob_spots in that cycle, and a dispatch is not visible at the head in that cycle.
//     - Lanes >= rob_outputs_valid are driven '0.
//   Per clock edge, in priority order:
//     1. reset: head=tail=count=0. Entries are not cleared.
//        Outputs after reset: rob_outputs_valid=0, rob_spots=min(DEPTH,N), rob_outputs='0, rob_tail=0.
//     2. flush: head=tail=count=0. Dispatch and retire in the same cycle are ignored.
//     3. Normal operation:
//        - head'  = (head + num_retiring) mod DEPTH
//        - entries[(tail+i) mod DEPTH] = rob_inputs[i] for i < rob_inputs_valid
//        - tail'  = (tail + rob_inputs_valid) mod DEPTH
//        - count' = count + rob_inputs_valid - num_retiring
//   Wrap: every modular add is done as add-then-subtract-DEPTH-if->=DEPTH in one step.
//     - Valid because each operand is < DEPTH and each increment is <= N <= DEPTH.
//     - Never use a % operator on a non-power-of-two DEPTH.
//   Simultaneous dispatch and retire: both apply.
//     - Safe because rob_spots excludes the entries being freed.
//     - Full (count=DEPTH) with retire 2 / dispatch 0: count goes to DEPTH-2.
//   Empty (count=0): rob_outputs_valid=0; num_retiring must be 0.
//   Illegal inputs (assertions in simulation only, no RTL recovery):
//     - rob_inputs_valid > rob_spots
//     - num_retiring > rob_outputs_valid
//   Latency: an entry dispatched in cycle t is presentable to retire in cycle t+1.
// STRUCTURE
//   sys_defs.svh already supplies ROB_PACKET, `N, `ROB_SZ and NUM_SCALAR_BITS.
//   Add to sys_defs.svh:
//     - ROB_IDX typedef, logic [$clog2(`ROB_SZ)-1:0]
//     - ROB_CNT typedef, logic [$clog2(`ROB_SZ+1)-1:0]
//   Add a wrap-add function rob_wrap_add(ROB_IDX, NUM_SCALAR_BITS) to a shared package so freelist/SQ reuse it.
//   Single module, no sub-module. Storage is a flop array with N write ports and N read ports.
// TESTING
//   - Reset, then dispatch 0 -> rob_outputs_valid=0, rob_spots=N, rob_tail=0.
//   - Dispatch N packets (NPC=0x0,0x4,..) in cycle 0, retire 0 -> in cycle 1 rob_outputs_valid=N, lane i NPC=4i, rob_spots=min(DEPTH-N,N).
//   - Fill to DEPTH, then next cycle dispatch 0 and retire 2 -> rob_spots=0 while full.
//       The cycle after: rob_spots=2, rob_outputs lane0 = third-oldest entry.
//   - Wrap (DEPTH=8 override, N=2): fill 7 and retire 6 so head=6; dispatch 4 -> entries land at 7,0,1,2.
//       Then rob_tail=3 and outputs are presented in dispatch order.
//   - Flush with rob_inputs_valid=2 and num_retiring=1 asserted -> next cycle count=0, rob_tail=0, and the dispatched entries are absent.
//   - Reset asserted mid-stream while full -> next cycle identical to post-reset state; random dispatch/retire vs. queue model for 10k cycles.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared ROB types and the modular index add used by the ROB, freelist and store queue.
package reorder_buffer_pkg;

  localparam int N      = 2;
  localparam int ROB_SZ = 8;
  localparam int NUM_SCALAR_W = $clog2(N + 1);

  typedef logic [NUM_SCALAR_W-1:0]     NUM_SCALAR_BITS;
  typedef logic [$clog2(ROB_SZ)-1:0]   ROB_IDX;
  typedef logic [$clog2(ROB_SZ+1)-1:0] ROB_CNT;

  typedef struct packed {
    logic [31:0] npc;
    logic [5:0]  tag;
  } ROB_PACKET;

  // Operands are < ROB_SZ and the increment is <= N <= ROB_SZ, so one subtract wraps.
  function automatic ROB_IDX rob_wrap_add(input ROB_IDX idx, input NUM_SCALAR_BITS inc);
    logic [$clog2(ROB_SZ):0] sum;
    sum = {1'b0, idx} + ($clog2(ROB_SZ)+1)'(inc);
    if (sum >= ($clog2(ROB_SZ)+1)'(ROB_SZ)) sum = sum - ($clog2(ROB_SZ)+1)'(ROB_SZ);
    return sum[$clog2(ROB_SZ)-1:0];
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: up to WIDTH dispatches at the tail and WIDTH
// retires at the head per cycle, with full flush. Outputs depend on registered state only.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = ROB_SZ,
  parameter int WIDTH = N
) (
  input  logic                              clock,
  input  logic                              reset,
  input  ROB_PACKET [WIDTH-1:0]             rob_inputs,
  input  logic [$clog2(WIDTH+1)-1:0]        rob_inputs_valid,
  output logic [$clog2(WIDTH+1)-1:0]        rob_spots,
  output ROB_PACKET [WIDTH-1:0]             rob_outputs,
  output logic [$clog2(WIDTH+1)-1:0]        rob_outputs_valid,
  input  logic [$clog2(WIDTH+1)-1:0]        num_retiring,
  input  logic                              flush,
  output logic [$clog2(DEPTH)-1:0]          rob_tail
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SB_W  = $clog2(WIDTH + 1);

  ROB_PACKET        entries_q [DEPTH];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] free_slots;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] idx,
                                                input logic [SB_W-1:0]  inc);
    logic [IDX_W:0] sum;
    sum = {1'b0, idx} + (IDX_W+1)'(inc);
    if (sum >= (IDX_W+1)'(DEPTH)) sum = sum - (IDX_W+1)'(DEPTH);
    return sum[IDX_W-1:0];
  endfunction

  always_comb begin
    head_d  = wrap_add(head_q, num_retiring);
    tail_d  = wrap_add(tail_q, rob_inputs_valid);
    count_d = count_q + CNT_W'(rob_inputs_valid) - CNT_W'(num_retiring);
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left out of reset; count_q alone decides what is live.
  always_ff @(posedge clock) begin
    if (!reset && !flush) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (SB_W'(i) < rob_inputs_valid) entries_q[wrap_add(tail_q, SB_W'(i))] <= rob_inputs[i];
      end
    end
  end

  always_comb begin
    free_slots        = CNT_W'(DEPTH) - count_q;
    rob_spots         = (free_slots >= CNT_W'(WIDTH)) ? SB_W'(WIDTH) : SB_W'(free_slots);
    rob_outputs_valid = (count_q >= CNT_W'(WIDTH)) ? SB_W'(WIDTH) : SB_W'(count_q);
    rob_tail          = tail_q;
    rob_outputs       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (SB_W'(i) < rob_outputs_valid) rob_outputs[i] = entries_q[wrap_add(head_q, SB_W'(i))];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !flush) begin
      assert (rob_inputs_valid <= rob_spots);
      assert (num_retiring <= rob_outputs_valid);
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed table plus corner sequences and a queue-model random phase for reorder_buffer (DEPTH=8, N=2).
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int WIDTH = 2;

  logic                 clock;
  logic                 reset;
  ROB_PACKET [WIDTH-1:0] rob_inputs;
  logic [1:0]           rob_inputs_valid;
  logic [1:0]           rob_spots;
  ROB_PACKET [WIDTH-1:0] rob_outputs;
  logic [1:0]           rob_outputs_valid;
  logic [1:0]           num_retiring;
  logic                 flush;
  logic [2:0]           rob_tail;

  int total;
  int bad;

  reorder_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset),
    .rob_inputs(rob_inputs), .rob_inputs_valid(rob_inputs_valid),
    .rob_spots(rob_spots), .rob_outputs(rob_outputs),
    .rob_outputs_valid(rob_outputs_valid), .num_retiring(num_retiring),
    .flush(flush), .rob_tail(rob_tail)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          disp;
    int          ret;
    bit          fl;
    logic [31:0] npc0;
    logic [31:0] npc1;
    int          e_valid;
    int          e_spots;
    int          e_tail;
    logic [31:0] e_l0;
    logic [31:0] e_l1;
  } vec_t;

  vec_t vq[$];
  logic [37:0] exp_q[$];

  function automatic ROB_PACKET mk(input logic [31:0] npc);
    ROB_PACKET p;
    p.npc = npc;
    p.tag = npc[7:2];
    return p;
  endfunction

  task automatic add(input int disp, input int ret, input bit fl, input logic [31:0] n0,
                     input logic [31:0] n1, input int ev, input int es, input int et,
                     input logic [31:0] l0, input logic [31:0] l1);
    vec_t v;
    v.disp = disp; v.ret = ret; v.fl = fl; v.npc0 = n0; v.npc1 = n1;
    v.e_valid = ev; v.e_spots = es; v.e_tail = et; v.e_l0 = l0; v.e_l1 = l1;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int disp, input int ret, input bit fl,
                       input ROB_PACKET p0, input ROB_PACKET p1);
    rob_inputs_valid = 2'(disp);
    num_retiring     = 2'(ret);
    flush            = fl;
    rob_inputs[0]    = p0;
    rob_inputs[1]    = p1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(input string tag, input int ev, input int es, input int et,
                             input ROB_PACKET l0, input ROB_PACKET l1);
    check({tag, ".valid"}, 64'(rob_outputs_valid), 64'(ev));
    check({tag, ".spots"}, 64'(rob_spots), 64'(es));
    check({tag, ".tail"},  64'(rob_tail), 64'(et));
    check({tag, ".lane0"}, 64'(rob_outputs[0]), 64'(l0));
    check({tag, ".lane1"}, 64'(rob_outputs[1]), 64'(l1));
  endtask

  initial begin
    int tail_m;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(0, 0, 0, '0, '0);
    tick();
    reset = 1'b0;

    // Each row: inputs for this cycle, and the outputs expected before this cycle's edge.
    add(2, 0, 0, 'h00, 'h04, 0, 2, 0, 'h00, 'h00);
    add(2, 0, 0, 'h08, 'h0C, 2, 2, 2, 'h00, 'h04);
    add(2, 0, 0, 'h10, 'h14, 2, 2, 4, 'h00, 'h04);
    add(2, 0, 0, 'h18, 'h1C, 2, 2, 6, 'h00, 'h04);
    add(0, 2, 0, 'h00, 'h00, 2, 0, 0, 'h00, 'h04);   // full: no spots
    add(2, 2, 0, 'h20, 'h24, 2, 2, 0, 'h08, 'h0C);   // third-oldest at head
    add(1, 1, 0, 'h28, 'h00, 2, 2, 2, 'h10, 'h14);
    add(0, 2, 0, 'h00, 'h00, 2, 2, 3, 'h14, 'h18);
    add(0, 2, 0, 'h00, 'h00, 2, 2, 3, 'h1C, 'h20);   // read wraps 7 -> 0
    add(0, 1, 0, 'h00, 'h00, 2, 2, 3, 'h24, 'h28);
    add(0, 1, 0, 'h00, 'h00, 1, 2, 3, 'h28, 'h00);
    add(2, 0, 0, 'h30, 'h34, 0, 2, 3, 'h00, 'h00);
    add(2, 1, 1, 'h38, 'h3C, 2, 2, 5, 'h30, 'h34);   // flush beats dispatch/retire
    add(2, 0, 0, 'h40, 'h44, 0, 2, 0, 'h00, 'h00);
    add(2, 0, 0, 'h48, 'h4C, 2, 2, 2, 'h40, 'h44);
    add(2, 0, 0, 'h50, 'h54, 2, 2, 4, 'h40, 'h44);
    add(1, 0, 0, 'h58, 'h00, 2, 2, 6, 'h40, 'h44);
    add(0, 2, 0, 'h00, 'h00, 2, 1, 7, 'h40, 'h44);
    add(0, 2, 0, 'h00, 'h00, 2, 2, 7, 'h48, 'h4C);
    add(0, 2, 0, 'h00, 'h00, 2, 2, 7, 'h50, 'h54);
    add(2, 0, 0, 'h60, 'h64, 1, 2, 7, 'h58, 'h00);   // head=6: lands at 7,0
    add(2, 1, 0, 'h68, 'h6C, 2, 2, 1, 'h58, 'h60);   // lands at 1,2
    add(0, 2, 0, 'h00, 'h00, 2, 2, 3, 'h60, 'h64);
    add(0, 2, 0, 'h00, 'h00, 2, 2, 3, 'h68, 'h6C);
    add(0, 0, 0, 'h00, 'h00, 0, 2, 3, 'h00, 'h00);

    foreach (vq[k]) begin
      drive(vq[k].disp, vq[k].ret, vq[k].fl, mk(vq[k].npc0), mk(vq[k].npc1));
      #1;
      check_state($sformatf("vec%0d", k), vq[k].e_valid, vq[k].e_spots, vq[k].e_tail,
                  mk(vq[k].e_l0), mk(vq[k].e_l1));
      tick();
    end

    // Fill from tail=3, then reset while full.
    for (int k = 0; k < 4; k++) begin
      drive(2, 0, 0, mk(32'h100 + 32'(8 * k)), mk(32'h104 + 32'(8 * k)));
      tick();
    end
    drive(0, 0, 0, '0, '0);
    #1;
    check_state("full", 2, 0, 3, mk(32'h100), mk(32'h104));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_state("post_reset", 0, 2, 0, '0, '0);

    // Random dispatch/retire/flush against the queue model.
    tail_m = 0;
    exp_q.delete();
    for (int c = 0; c < 10000; c++) begin
      int ev, es, d, r;
      bit fl;
      ROB_PACKET p0, p1, e0, e1;
      ev = (exp_q.size() >= 2) ? 2 : exp_q.size();
      es = (DEPTH - exp_q.size() >= 2) ? 2 : DEPTH - exp_q.size();
      d  = $urandom_range(0, es);
      r  = $urandom_range(0, ev);
      fl = ($urandom_range(0, 63) == 0);
      p0 = mk({$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
      p1 = mk({$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
      e0 = (exp_q.size() > 0) ? ROB_PACKET'(exp_q[0]) : ROB_PACKET'('0);
      e1 = (exp_q.size() > 1) ? ROB_PACKET'(exp_q[1]) : ROB_PACKET'('0);
      drive(d, r, fl, p0, p1);
      #1;
      check_state("rand", ev, es, tail_m, e0, e1);
      tick();
      if (fl) begin
        exp_q.delete();
        tail_m = 0;
      end else begin
        for (int k = 0; k < r; k++) void'(exp_q.pop_front());
        if (d > 0) exp_q.push_back(38'(p0));
        if (d > 1) exp_q.push_back(38'(p1));
        tail_m = (tail_m + d) % DEPTH;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
